// File: rtl/act_pkg.sv
// Shared types and helpers for the per-lane activation pipeline.
// Breakpoints scale with the lane width, so every width uses the same curve shape.
package act_pkg;

   typedef enum logic [1:0] {
      ACT_BYPASS = 2'd0,
      ACT_RELU   = 2'd1,
      ACT_SILU   = 2'd2,
      ACT_LEAKY  = 2'd3
   } act_mode_e;

   // Outer SiLU breakpoint unit: 1 << (w-3)
   function automatic int act_q(input int w);
      return 1 << (w - 3);
   endfunction

   // SiLU offset unit: 1 << (w-5)
   function automatic int act_r(input int w);
      return 1 << (w - 5);
   endfunction

   // Clamp v to the signed w-bit range
   function automatic int act_sat(input int v, input int w);
      int hi;
      int lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/act_lane.sv
// One activation lane: purely combinational, computes in DATA_WIDTH+2 bits
// and saturates back to DATA_WIDTH.
module act_lane
   import act_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] x,
   input  logic [1:0]            mode,
   input  logic                  mask,
   output logic [DATA_WIDTH-1:0] y
);

   localparam int unsigned EW = DATA_WIDTH + 2;
   localparam int QI = act_q(DATA_WIDTH);
   localparam int RI = act_r(DATA_WIDTH);

   localparam logic signed [EW-1:0] NEG_3Q = EW'(-3 * QI);
   localparam logic signed [EW-1:0] NEG_Q  = EW'(-QI);
   localparam logic signed [EW-1:0] POS_3Q = EW'(3 * QI);
   localparam logic signed [EW-1:0] R1     = EW'(RI);
   localparam logic signed [EW-1:0] R3     = EW'(3 * RI);

   logic signed [EW-1:0] xe;
   logic signed [EW-1:0] acc;

   assign xe = {{2{x[DATA_WIDTH-1]}}, x};

   always_comb begin
      acc = xe;
      case (act_mode_e'(mode))
         ACT_BYPASS: acc = xe;
         ACT_RELU:   acc = (xe < 0) ? '0 : xe;
         ACT_SILU: begin
            if (xe < NEG_3Q)      acc = '0;
            else if (xe < NEG_Q)  acc = (xe >>> 2) + R3;
            else if (xe < 0)      acc = (xe >>> 1) + R1;
            else if (xe < POS_3Q) acc = (xe >>> 1) + (xe >>> 2) + (xe >>> 3);
            else                  acc = xe;
         end
         ACT_LEAKY:  acc = (xe < 0) ? (xe >>> 3) : xe;
         default:    acc = xe;
      endcase
   end

   always_comb begin
      y = '0;
      if (mask) y = DATA_WIDTH'(act_sat(int'(acc), DATA_WIDTH));
   end

endmodule

// File: rtl/act_unit_pipe.sv
// Two-stage activation pipeline with valid/ready backpressure, per-lane mask
// and an accepted-beat counter.
module act_unit_pipe
   import act_pkg::*;
#(
   parameter int unsigned BUS_NUM    = 16,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [1:0]                    in_mode,
   input  logic [BUS_NUM-1:0]            in_mask,
   input  logic [BUS_NUM*DATA_WIDTH-1:0] in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BUS_NUM-1:0]            out_mask,
   output logic [BUS_NUM*DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]          beat_cnt
);

   logic                          s1_valid;
   logic [1:0]                    s1_mode;
   logic [BUS_NUM-1:0]            s1_mask;
   logic [BUS_NUM*DATA_WIDTH-1:0] s1_data;

   logic                          s2_valid;
   logic [BUS_NUM-1:0]            s2_mask;
   logic [BUS_NUM*DATA_WIDTH-1:0] s2_data;

   logic                          s1_adv;
   logic                          s2_adv;
   logic [BUS_NUM*DATA_WIDTH-1:0] act_res;

   // Ready depends only on registered valids and out_ready, never on in_valid
   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   for (genvar i = 0; i < BUS_NUM; i++) begin : g_lane
      act_lane #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_lane (
         .x    (s1_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .mode (s1_mode),
         .mask (s1_mask[i]),
         .y    (act_res[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mode  <= '0;
         s1_mask  <= '0;
         s1_data  <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_mode <= in_mode;
            s1_mask <= in_mask;
            s1_data <= in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_mask  <= '0;
         s2_data  <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_mask <= s1_mask;
            s2_data <= act_res;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) beat_cnt <= '0;
      else if (in_valid && s1_adv) beat_cnt <= beat_cnt + CNT_WIDTH'(1);
   end

   assign out_valid = s2_valid;
   assign out_mask  = s2_mask;
   assign out_data  = s2_data;

endmodule

// File: tb/tb_act_unit_pipe.sv
// Scoreboard bench for act_unit_pipe: W=8/16-lane and W=12/4-lane instances.
module tb_act_unit_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   // W=8, 16 lanes
   logic         i8_valid, i8_ready, o8_valid, o8_ready;
   logic [1:0]   i8_mode;
   logic [15:0]  i8_mask, o8_mask;
   logic [127:0] i8_data, o8_data;
   logic [31:0]  cnt8;

   // W=12, 4 lanes
   logic         i12_valid, i12_ready, o12_valid, o12_ready;
   logic [1:0]   i12_mode;
   logic [3:0]   i12_mask, o12_mask;
   logic [47:0]  i12_data, o12_data;
   logic [31:0]  cnt12;

   act_unit_pipe #(.BUS_NUM(16), .DATA_WIDTH(8), .CNT_WIDTH(32)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(i8_valid), .in_ready(i8_ready),
      .in_mode(i8_mode), .in_mask(i8_mask), .in_data(i8_data),
      .out_valid(o8_valid), .out_ready(o8_ready), .out_mask(o8_mask),
      .out_data(o8_data), .beat_cnt(cnt8)
   );

   act_unit_pipe #(.BUS_NUM(4), .DATA_WIDTH(12), .CNT_WIDTH(32)) u_dut12 (
      .clk(clk), .rst_n(rst_n), .in_valid(i12_valid), .in_ready(i12_ready),
      .in_mode(i12_mode), .in_mask(i12_mask), .in_data(i12_data),
      .out_valid(o12_valid), .out_ready(o12_ready), .out_mask(o12_mask),
      .out_data(o12_data), .beat_cnt(cnt12)
   );

   typedef struct packed { logic [127:0] d; logic [15:0] m; } exp8_t;
   typedef struct packed { logic [47:0] d; logic [3:0] m; } exp12_t;
   exp8_t  sb8[$];
   exp12_t sb12[$];
   int unsigned pop_cyc[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor for the 8-bit instance: scoreboard pop plus hold-while-stalled check
   logic         prev_stall = 1'b0;
   logic [127:0] prev_data;
   logic [15:0]  prev_mask;
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && o8_valid) begin
            check("stall_data_hold", o8_data, prev_data);
            check("stall_mask_hold", 128'(o8_mask), 128'(prev_mask));
         end
         if (o8_valid && o8_ready) begin
            if (sb8.size() == 0) begin
               check("unexpected_beat8", 128'(1), 128'(0));
            end else begin
               exp8_t e;
               e = sb8.pop_front();
               check("out_data8", o8_data, e.d);
               check("out_mask8", 128'(o8_mask), 128'(e.m));
               pop_cyc.push_back(cyc);
            end
         end
         prev_stall = o8_valid && !o8_ready;
         prev_data  = o8_data;
         prev_mask  = o8_mask;
      end
   end

   always @(negedge clk) begin
      #2;
      if (rst_n && o12_valid && o12_ready) begin
         if (sb12.size() == 0) begin
            check("unexpected_beat12", 128'(1), 128'(0));
         end else begin
            exp12_t e;
            e = sb12.pop_front();
            check("out_data12", 128'(o12_data), 128'(e.d));
            check("out_mask12", 128'(o12_mask), 128'(e.m));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the transfer edge
   task automatic send8(input logic [1:0] m, input logic [15:0] mk,
                        input logic [127:0] d, input logic [127:0] exp_d);
      int unsigned n;
      n = 0;
      i8_valid = 1'b1; i8_mode = m; i8_mask = mk; i8_data = d;
      #1;
      while (!i8_ready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      if (!i8_ready) begin
         check("in_ready_timeout", 128'(0), 128'(1));
      end else begin
         sb8.push_back('{d: exp_d, m: mk});
      end
      @(negedge clk);
      i8_valid = 1'b0;
   endtask

   task automatic send12(input logic [1:0] m, input logic [3:0] mk,
                         input logic [47:0] d, input logic [47:0] exp_d);
      int unsigned n;
      n = 0;
      i12_valid = 1'b1; i12_mode = m; i12_mask = mk; i12_data = d;
      #1;
      while (!i12_ready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      if (!i12_ready) check("in_ready12_timeout", 128'(0), 128'(1));
      else sb12.push_back('{d: exp_d, m: mk});
      @(negedge clk);
      i12_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned n;
      n = 0;
      while ((sb8.size() != 0 || sb12.size() != 0) && n < 60) begin
         @(negedge clk); n++;
      end
      @(negedge clk);
      check("drain", 128'(sb8.size() + sb12.size()), 128'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_out_valid8", 128'(o8_valid), 128'(0));
      check("rst_out_valid12", 128'(o12_valid), 128'(0));
      sb8.delete();
      sb12.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_beat_cnt", 128'(cnt8), 128'(0));
      check("rst_in_ready", 128'(i8_ready), 128'(1));
      check("rst_out_data", o8_data, 128'(0));
      @(negedge clk);
   endtask

   function automatic logic [127:0] pack8(input int v[8]);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(v[i % 8]);
      return r;
   endfunction

   function automatic logic [127:0] fill8(input int v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(v);
      return r;
   endfunction

   int silu_in[8]  = '{-100, -64, -10, 40, 100, -128, 0, 95};
   int silu_exp[8] = '{0, 8, 3, 35, 100, 0, 0, 81};
   logic         low_seen;
   logic [127:0] d_tmp;

   task automatic scenario_silu();
      send8(2'd2, 16'hFFFF, pack8(silu_in), pack8(silu_exp));
      #2;
      check("latency_cycle1_low", 128'(o8_valid), 128'(0));
      @(negedge clk); #2;
      check("latency_cycle2_high", 128'(o8_valid), 128'(1));
      @(negedge clk);
      wait_drain();
      check("beat_cnt_silu", 128'(cnt8), 128'(1));
   endtask

   initial begin
      i8_valid = 0; i8_mode = 0; i8_mask = 0; i8_data = 0; o8_ready = 1;
      i12_valid = 0; i12_mode = 0; i12_mask = 0; i12_data = 0; o12_ready = 1;
      @(negedge clk); #1;
      check("reset_out_valid", 128'(o8_valid), 128'(0));
      check("reset_in_ready", 128'(i8_ready), 128'(1));
      check("reset_beat_cnt", 128'(cnt8), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: SiLU breakpoints and latency
      scenario_silu();

      // 2: mode sweep back-to-back, no bubbles
      do_reset();
      send8(2'd0, 16'hFFFF, fill8(-16), fill8(-16));
      send8(2'd1, 16'hFFFF, fill8(-16), fill8(0));
      send8(2'd2, 16'hFFFF, fill8(-16), fill8(0));
      send8(2'd3, 16'hFFFF, fill8(-16), fill8(-2));
      wait_drain();
      check("beat_cnt_sweep", 128'(cnt8), 128'(4));
      if (pop_cyc.size() >= 4) begin
         for (int i = 1; i < 4; i++)
            check("no_bubble", 128'(pop_cyc[pop_cyc.size()-4+i] - pop_cyc[pop_cyc.size()-5+i]), 128'(1));
      end else begin
         check("sweep_pop_count", 128'(pop_cyc.size()), 128'(4));
      end

      // 3: mask
      do_reset();
      d_tmp = '0;
      for (int i = 0; i < 8; i++) d_tmp[i*8 +: 8] = 8'd50;
      send8(2'd1, 16'h00FF, fill8(50), d_tmp);
      wait_drain();

      // 4: backpressure with incrementing data
      do_reset();
      low_seen = 1'b0;
      fork
         begin
            for (int k = 1; k <= 10; k++) begin
               for (int i = 0; i < 16; i++) d_tmp[i*8 +: 8] = 8'(k * 4 + i);
               send8(2'd0, 16'hFFFF, d_tmp, d_tmp);
            end
         end
         begin
            for (int c = 0; c < 14; c++) begin
               o8_ready = !(c >= 3 && c <= 8);
               #1;
               if (!i8_ready) low_seen = 1'b1;
               @(negedge clk);
            end
            o8_ready = 1'b1;
         end
      join
      wait_drain();
      check("in_ready_fell", 128'(low_seen), 128'(1));
      check("beat_cnt_bp", 128'(cnt8), 128'(10));

      // 5: reset with both stages full
      do_reset();
      o8_ready = 1'b0;
      send8(2'd0, 16'hFFFF, fill8(7), fill8(7));
      send8(2'd0, 16'hFFFF, fill8(9), fill8(9));
      #1;
      check("full_out_valid", 128'(o8_valid), 128'(1));
      check("full_in_ready", 128'(i8_ready), 128'(0));
      @(negedge clk);
      do_reset();
      o8_ready = 1'b1;
      scenario_silu();

      // 6: W=12, 4 lanes, SiLU
      send12(2'd2, 4'hF, {12'sd2047, 12'sd200, -12'sd800, -12'sd1600},
                         {12'sd2047, 12'sd175, 12'sd184, 12'sd0});
      wait_drain();
      check("beat_cnt12", 128'(cnt12), 128'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
